// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: multi-mode log-stage barrel shifter with valid/ready pipeline and carry/zero flags
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int REG_EVERY = 1,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);
  localparam int L = (SHW + REG_EVERY - 1) / REG_EVERY;

  logic advance, z_ok;

  // One 2:1 mux stage shifting by 2^k; returns {carry, data}. SRA refills with the
  // current MSB, which every earlier SRA stage has preserved as the original sign.
  function automatic logic [WIDTH:0] stage(input logic [WIDTH-1:0] x, input logic cin,
                                           input logic [1:0] mode, input logic en, input int k);
    logic [WIDTH-1:0] y;
    logic c;
    int n;
    n = 1 << k;
    y = mode == 2'b00 ? x << n :
        mode == 2'b01 ? x >> n :
        mode == 2'b10 ? $unsigned($signed(x) >>> n) :
                        (x >> n) | (x << (WIDTH - n));
    c = mode == 2'b00 ? 1'(x >> (WIDTH - n)) :
        mode == 2'b11 ? y[WIDTH-1] :
                        1'(x >> (n - 1));
    return en ? {c, y} : {cin, x};
  endfunction

  assign advance   = !out_valid | out_ready;
  assign in_ready  = rst_n & advance;
  assign out_valid = st[L-1].v_q;
  assign out_data  = st[L-1].d_q;
  assign out_carry = st[L-1].c_q;
  assign out_zero  = z_ok & ~|out_data;

  for (genvar g = 0; g < L; g++) begin : st
    logic vi, ci, cn, v_q, c_q;
    logic [WIDTH-1:0] di, dn, d_q;
    logic [1:0] mi;
    logic [SHW-1:0] si;
    if (g == 0) begin : src
      assign vi = in_valid & in_ready;
      assign di = in_data;
      assign ci = 1'b0;
      assign mi = in_mode;
      assign si = in_shamt;
    end else begin : src
      assign vi = st[g-1].v_q;
      assign di = st[g-1].d_q;
      assign ci = st[g-1].c_q;
      assign mi = st[g-1].ctl.m_q;
      assign si = st[g-1].ctl.s_q;
    end
    // apply the mux stages that belong to this register group
    always_comb begin
      dn = di;
      cn = ci;
      for (int k = 0; k < SHW; k++)
        if (k / REG_EVERY == g) {cn, dn} = stage(dn, cn, mi, 1'(si >> k), k);
    end
    // group output register; data only loads for a valid slot so outputs never move while idle
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
        c_q <= 1'b0;
      end else if (advance) begin
        v_q <= vi;
        if (vi) begin
          d_q <= dn;
          c_q <= cn;
        end
      end
    if (g < L - 1) begin : ctl
      logic [1:0] m_q;
      logic [SHW-1:0] s_q;
      // mode and shift amount travel with the beat to the later groups
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          m_q <= '0;
          s_q <= '0;
        end else if (advance && vi) begin
          m_q <= mi;
          s_q <= si;
        end
    end
  end

  // zero flag stays low until a real result has reached the output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) z_ok <= 1'b0;
    else if (advance && st[L-1].vi) z_ok <= 1'b1;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed and streamed checks of three shifter configurations in parallel
module tb_pipelined_barrel_shifter;
  localparam int WS [3] = '{32, 8, 16};
  localparam int RS [3] = '{1, 2, 4};
  localparam int LS [3] = '{5, 2, 1};

  typedef struct {logic [32:0] e; int cyc;} ex_t;
  typedef struct {logic [31:0] d; logic c; logic z;} res_t;

  logic clk = 1'b0;
  logic rst_n, ordy, rand_rdy, lat_chk, pr;
  logic [2:0] iv;
  logic [31:0] sd;
  logic [4:0] ss;
  logic [1:0] sm;
  logic ir [3], ov [3], oc [3], oz [3];
  logic [31:0] od [3];
  logic pv [3], pc [3], pz [3], pok [3];
  logic [31:0] pd [3];
  ex_t exq [3][$];
  res_t got [$];
  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : dut_g
    localparam int W = WS[g];
    localparam int S = $clog2(W);
    logic [W-1:0] dout;
    pipelined_barrel_shifter #(.WIDTH(W), .REG_EVERY(RS[g])) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]),
      .in_data(sd[W-1:0]), .in_shamt(ss[S-1:0]), .in_mode(sm),
      .out_valid(ov[g]), .out_ready(ordy), .out_data(dout),
      .out_carry(oc[g]), .out_zero(oz[g]));
    assign od[g] = 32'(dout);
  end

  task automatic chk(input string tag, input logic [63:0] g, input logic [63:0] e);
    total++;
    assert (g === e) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, g, e);
    end
  endtask

  // bit-at-a-time reference shifter of width w
  function automatic logic [32:0] model(input logic [31:0] d, input int s, input logic [1:0] m, input int w);
    logic [31:0] msk, x;
    logic c;
    msk = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    x = d & msk;
    c = 1'b0;
    for (int j = 0; j < s; j++) begin
      if (m == 2'd0) begin
        c = 1'(x >> (w - 1));
        x = (x << 1) & msk;
      end else if (m == 2'd3) begin
        x = (x >> 1) | (32'(x[0]) << (w - 1));
        c = 1'(x >> (w - 1));
      end else begin
        c = x[0];
        x = (x >> 1) | (32'(m == 2'd2 && 1'(x >> (w - 1))) << (w - 1));
      end
    end
    return {c, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ordy = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] d, input int s, input logic [1:0] m);
    logic [2:0] acc;
    int n = 0;
    sd = d;
    ss = 5'(s);
    sm = m;
    iv = 3'b111;
    while (iv != 3'b000 && n < 200) begin
      @(negedge clk);
      acc = iv & {ir[2], ir[1], ir[0]};
      tick();
      iv = iv & ~acc;
      n++;
    end
    if (iv != 3'b000) chk("send_timeout", 64'(iv), 64'd0);
    iv = 3'b000;
  endtask

  task automatic expect0(input logic [31:0] d, input logic c, input logic z);
    res_t r;
    int n = 0;
    while (got.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    if (got.size() == 0) chk("wait_out", 64'(got.size()), 64'd1);
    else begin
      r = got.pop_front();
      chk("data", 64'(r.d), 64'(d));
      chk("carry", 64'(r.c), 64'(c));
      chk("zero", 64'(r.z), 64'(z));
    end
  endtask

  always @(negedge clk) begin
    ex_t e;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        exq[i].delete();
        pok[i] = 1'b0;
      end else begin
        chk($sformatf("d%0d_ready", i), 64'(ir[i]), 64'(!ov[i] || ordy));
        if (pok[i] && ((pv[i] && !pr) || (!pv[i] && !ov[i])))
          chk($sformatf("d%0d_hold", i), 64'({oc[i], oz[i], od[i]}), 64'({pc[i], pz[i], pd[i]}));
        if (iv[i] && ir[i])
          exq[i].push_back('{model(sd, int'(ss) & (WS[i] - 1), sm, WS[i]), cyc});
        if (ov[i] && ordy) begin
          if (exq[i].size() == 0) chk($sformatf("d%0d_stale", i), 64'(exq[i].size()), 64'd1);
          else begin
            e = exq[i].pop_front();
            chk($sformatf("d%0d_data", i), 64'(od[i]), 64'(e.e[31:0]));
            chk($sformatf("d%0d_carry", i), 64'(oc[i]), 64'(e.e[32]));
            chk($sformatf("d%0d_zero", i), 64'(oz[i]), 64'(e.e[31:0] == 32'd0));
            if (lat_chk) chk($sformatf("d%0d_lat", i), 64'(cyc - e.cyc), 64'(LS[i]));
            if (i == 0) got.push_back('{od[0], oc[0], oz[0]});
          end
        end
        pv[i] = ov[i];
        pd[i] = od[i];
        pc[i] = oc[i];
        pz[i] = oz[i];
        pok[i] = 1'b1;
      end
    end
    pr = ordy;
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ordy = 1'b1;
    rand_rdy = 1'b0;
    lat_chk = 1'b1;
    iv = 3'b000;
    sd = '0;
    ss = '0;
    sm = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_valid", i), 64'(ov[i]), 64'd0);
      chk($sformatf("rst%0d_ready", i), 64'(ir[i]), 64'd0);
      chk($sformatf("rst%0d_out", i), 64'({oc[i], oz[i], od[i]}), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("rel%0d_ready", i), 64'(ir[i]), 64'd1);
    tick();
    send(32'h8000_0001, 1, 2'd0);  expect0(32'h0000_0002, 1'b1, 1'b0);
    send(32'h8000_00F0, 4, 2'd2);  expect0(32'hF800_000F, 1'b0, 1'b0);
    send(32'h8000_00F0, 4, 2'd1);  expect0(32'h0800_000F, 1'b0, 1'b0);
    send(32'h0000_0001, 1, 2'd3);  expect0(32'h8000_0000, 1'b1, 1'b0);
    send(32'h1234_5678, 0, 2'd2);  expect0(32'h1234_5678, 1'b0, 1'b0);
    send(32'h0000_00A5, 0, 2'd3);  expect0(32'h0000_00A5, 1'b0, 1'b0);
    send(32'h0000_0001, 31, 2'd0); expect0(32'h8000_0000, 1'b0, 1'b0);
    send(32'h0000_0001, 1, 2'd1);  expect0(32'h0000_0000, 1'b1, 1'b1);
    lat_chk = 1'b0;
    rand_rdy = 1'b1;
    repeat (20) send($urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    repeat (40) tick();
    rand_rdy = 1'b0;
    ordy = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 3; i++) chk($sformatf("drain%0d", i), 64'(exq[i].size()), 64'd0);
    got.delete();
    lat_chk = 1'b1;
    send(32'hDEAD_BEEF, 3, 2'd0);
    send(32'h0F0F_0F0F, 5, 2'd2);
    send(32'h1357_9BDF, 7, 2'd3);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid%0d_valid", i), 64'(ov[i]), 64'd0);
      chk($sformatf("mid%0d_ready", i), 64'(ir[i]), 64'd0);
    end
    chk("mid0_data", 64'(od[0]), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("post%0d_ready", i), 64'(ir[i]), 64'd1);
    repeat (10) tick();
    chk("post_stale0", 64'(got.size()), 64'd0);
    send(32'h0000_00FF, 4, 2'd0);
    expect0(32'h0000_0FF0, 1'b0, 1'b0);
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined, multi-mode barrel shifter built from log2(WIDTH) cascaded 2:1 mux stages.
- Pipeline registers sit between groups of stages, and a valid/ready handshake runs at both ends.
- Supports logical left, logical right, arithmetic right and rotate right, and produces carry-out and zero flags.
- Used as the shift unit feeding the ALU result mux in the datapath.

Parameters:
- WIDTH, 32, data width in bits. Must be a power of two and at least 4. SHW = log2(WIDTH) is derived internally.
- REG_EVERY, 1, number of mux stages between pipeline registers (1..SHW). Latency L = ceil(SHW/REG_EVERY) cycles.

Ports:
- clk  in  1  sole clock; all flops update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, 0..WIDTH-1.
- in_mode  in  2  shift mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  shifted result.
- out_carry  out  1  last bit shifted out. For ROR, this is out_data[WIDTH-1].
- out_zero  out  1  1 when out_data == 0.

Behaviour:
- Stage k (k = 0..SHW-1) shifts by 2^k when shamt bit k is 1; otherwise the value passes through.
- Stages run in order of increasing k. Mode and the remaining shamt bits travel with the data through every pipeline register.
- Fill bits:
  - SLL fills 0 at the LSB.
  - SRL fills 0 at the MSB.
  - SRA fills the original in_data[WIDTH-1] at the MSB in every stage.
  - ROR wraps the bits shifted out of the LSB into the MSB.
- Carry, for shamt = s > 0:
  - SLL: in_data[WIDTH-s].
  - SRL and SRA: in_data[s-1].
  - ROR: out_data[WIDTH-1].
  - s = 0: carry is 0 in all modes.
  - Carry is tracked per stage and registered with the data, so it is not a separate computation path.
- out_zero is computed combinationally from the final registered out_data.
- Pipeline control uses a global stall:
  - advance = !out_valid | out_ready.
  - in_ready = rst_n & advance.
  - When advance = 1, every pipeline register loads from its predecessor. Stage-0 input registers load {in_valid & in_ready, operands}.
  - When advance = 0, all registers hold.
  - Bubbles are not compressed.
- A beat is accepted when in_valid & in_ready. Its result appears with out_valid = 1 exactly L cycles later if the pipeline never stalls. Each cycle spent with out_valid & !out_ready adds one cycle.
- Each stall cycle freezes out_data, out_carry and out_zero. Results leave in input order with no loss and no duplication.
- Full throughput is one beat per cycle when out_ready is held at 1.
- Invalid slots carry don't-care data internally, but out_data, out_carry and out_zero must not change while out_valid = 0. Implement this by gating data-register enables with the slot's valid bit.
- Reset: while rst_n = 0, all valid bits are 0, out_data = 0, out_carry = 0, out_zero = 0 and in_ready = 0. Asserting reset mid-operation discards all in-flight beats immediately, without waiting for a clock edge.
- After rst_n rises, in_ready = 1 in the same cycle.
- If in_shamt is driven with X while in_valid = 0, nothing propagates to the outputs.

Test Plan:
1. WIDTH=32, REG_EVERY=1 (L=5). Send SLL, in_data=0x8000_0001, shamt=1, out_ready=1 -> 5 cycles later out_valid=1, out_data=0x0000_0002, out_carry=1, out_zero=0.
2. SRA, in_data=0x8000_00F0, shamt=4 -> out_data=0xF800_000F, carry=0. Same beat as SRL -> out_data=0x0800_000F.
3. ROR, in_data=0x0000_0001, shamt=1 -> out_data=0x8000_0000, carry=1. shamt=0 in any mode -> out_data=in_data, carry=0. SLL of 0x1 by 31 -> 0x8000_0000. SRL of 0x1 by 1 -> 0, zero=1.
4. Back-to-back stream of 20 random beats with out_ready toggling pseudo-randomly -> results match a reference model in order. in_ready == !out_valid | out_ready every cycle. Outputs are stable whenever out_valid & !out_ready.
5. Pull rst_n low for 1 cycle with 3 beats in flight -> out_valid and in_ready drop to 0 immediately. No stale beat emerges after release. First post-reset beat has latency L.
6. Repeat scenarios 1-4 with WIDTH=8, REG_EVERY=2 (L=2) and with WIDTH=16, REG_EVERY=4 (L=1) -> identical functional results at the new latency.
